// File: rtl/hole_field_scanner.sv
// Scans up to NUM_HOLES hole slots, one per cycle, for a ball inside the capture radius.
// Optional feature macro HIT_DIST_EN adds o_dist_sq, the squared distance of the hit slot.
module hole_field_scanner #(
  parameter int NUM_HOLES = 8,
  parameter int COORD_W   = 10,
  parameter int RADIUS    = 16,
  parameter int IDX_W     = 3
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  input  logic                           i_clear,
  input  logic [COORD_W-1:0]             i_bl_x,
  input  logic [COORD_W-1:0]             i_bl_y,
  input  logic [NUM_HOLES*COORD_W-1:0]   i_hole_x,
  input  logic [NUM_HOLES*COORD_W-1:0]   i_hole_y,
  input  logic [NUM_HOLES-1:0]           i_hole_mask,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_fall_in,
  output logic [IDX_W-1:0]               o_hole_idx
`ifdef HIT_DIST_EN
  ,
  output logic [2*COORD_W+2:0]           o_dist_sq
`endif
);

  localparam int SUM_W = 2*COORD_W+3;
  localparam logic [SUM_W-1:0] R_SQ = SUM_W'(RADIUS*RADIUS);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t                    r_state;
  logic [IDX_W-1:0]          r_idx;
  logic [COORD_W-1:0]        r_bl_x;
  logic [COORD_W-1:0]        r_bl_y;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_fall_in;
  logic [IDX_W-1:0]          r_hole_idx;
`ifdef HIT_DIST_EN
  logic [SUM_W-1:0]          r_dist_sq;
`endif

  logic [COORD_W-1:0]        w_hx;
  logic [COORD_W-1:0]        w_hy;
  logic signed [COORD_W:0]   w_dx;
  logic signed [COORD_W:0]   w_dy;
  logic signed [SUM_W-1:0]   w_sum;
  logic                      w_hit;

  // Differences are taken one bit wider and signed so a ball left of / above
  // the hole never wraps into a small positive distance.
  function automatic logic signed [COORD_W:0] diff(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

  function automatic logic signed [SUM_W-1:0] sq(input logic signed [COORD_W:0] v);
    logic signed [SUM_W-1:0] ve;
    ve = SUM_W'(v);
    return ve * ve;
  endfunction

  assign w_hx  = i_hole_x[int'(r_idx)*COORD_W +: COORD_W];
  assign w_hy  = i_hole_y[int'(r_idx)*COORD_W +: COORD_W];
  assign w_dx  = diff(r_bl_x, w_hx);
  assign w_dy  = diff(r_bl_y, w_hy);
  assign w_sum = sq(w_dx) + sq(w_dy);
  assign w_hit = i_hole_mask[r_idx] && ($unsigned(w_sum) <= R_SQ);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_fall_in  <= 1'b0;
      r_hole_idx <= '0;
`ifdef HIT_DIST_EN
      r_dist_sq  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start && !r_fall_in) begin
            r_bl_x  <= i_bl_x;
            r_bl_y  <= i_bl_y;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_hit) begin
            r_fall_in  <= 1'b1;
            r_hole_idx <= r_idx;
`ifdef HIT_DIST_EN
            r_dist_sq  <= $unsigned(w_sum);
`endif
            r_done     <= 1'b1;
            r_state    <= S_DONE;
          end else if (r_idx == IDX_W'(NUM_HOLES-1)) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_fall_in  = r_fall_in;
  assign o_hole_idx = r_hole_idx;
`ifdef HIT_DIST_EN
  assign o_dist_sq  = r_dist_sq;
`endif

endmodule

// File: tb/tb_hole_field_scanner.sv
// Scoreboard bench for hole_field_scanner: each started scan pushes its expected
// outcome, which is popped and compared when o_done appears.
module tb_hole_field_scanner;

  localparam int NH = 8;
  localparam int CW = 10;
  localparam int IW = 3;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_start = 1'b0;
  logic            i_clear = 1'b0;
  logic [CW-1:0]   i_bl_x = '0;
  logic [CW-1:0]   i_bl_y = '0;
  logic [NH*CW-1:0] i_hole_x = '0;
  logic [NH*CW-1:0] i_hole_y = '0;
  logic [NH-1:0]   i_hole_mask = '1;
  logic            o_busy;
  logic            o_done;
  logic            o_fall_in;
  logic [IW-1:0]   o_hole_idx;
`ifdef HIT_DIST_EN
  logic [2*CW+2:0] o_dist_sq;
`endif

  hole_field_scanner #(.NUM_HOLES(NH), .COORD_W(CW), .RADIUS(16), .IDX_W(IW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_clear(i_clear),
    .i_bl_x(i_bl_x), .i_bl_y(i_bl_y), .i_hole_x(i_hole_x), .i_hole_y(i_hole_y),
    .i_hole_mask(i_hole_mask), .o_busy(o_busy), .o_done(o_done),
    .o_fall_in(o_fall_in), .o_hole_idx(o_hole_idx)
`ifdef HIT_DIST_EN
    , .o_dist_sq(o_dist_sq)
`endif
  );

  always #5 i_clk = ~i_clk;

  // lat = rising edges after the start edge T until o_done is seen (#1 after the edge);
  // o_done high in cycle T+k+2 means it appears just after edge T+k+1.
  typedef struct {
    int lat;
    bit fall;
    int idx;
    int dsq;
  } exp_t;
  exp_t sb[$];

  int n_pass = 0;
  int n_total = 0;

  task automatic set_hole(input int k, input int x, input int y);
    i_hole_x[k*CW +: CW] = CW'(x);
    i_hole_y[k*CW +: CW] = CW'(y);
  endtask

  task automatic all_far();
    for (int k = 0; k < NH; k++) set_hole(k, 500, 900);
    i_hole_mask = '1;
  endtask

  task automatic do_clear();
    @(negedge i_clk); i_clear = 1'b1;
    @(posedge i_clk); #1; i_clear = 1'b0;
  endtask

  task automatic start_scan(input int bx, input int by, input int lat, input bit fall,
                            input int idx, input int dsq);
    exp_t e;
    e.lat = lat; e.fall = fall; e.idx = idx; e.dsq = dsq;
    sb.push_back(e);
    @(negedge i_clk);
    i_bl_x = CW'(bx); i_bl_y = CW'(by); i_start = 1'b1;
    @(posedge i_clk); #1; i_start = 1'b0;
  endtask

  // n0 = edges already elapsed since the start edge
  task automatic wait_done(input string name, input int n0);
    exp_t e;
    int n;
    bit found;
    e = sb.pop_front();
    n = n0; found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge i_clk); #1; n++;
      if (o_done === 1'b1) begin found = 1'b1; break; end
    end
    n_total++;
    if (!found) $display("FAIL %s timeout: no o_done within 40 cycles", name);
    else n_pass++;
    n_total++;
    if (n !== e.lat) $display("FAIL %s latency: got %0d edges, want %0d", name, n, e.lat);
    else n_pass++;
    n_total++;
    if (o_fall_in !== e.fall) $display("FAIL %s fall_in: got %b want %b", name, o_fall_in, e.fall);
    else n_pass++;
    n_total++;
    if (o_hole_idx !== IW'(e.idx)) $display("FAIL %s idx: got %0d want %0d", name, o_hole_idx, e.idx);
    else n_pass++;
`ifdef HIT_DIST_EN
    n_total++;
    if (o_dist_sq !== (2*CW+3)'(e.dsq)) $display("FAIL %s dist_sq: got %0d want %0d", name, o_dist_sq, e.dsq);
    else n_pass++;
`endif
    @(posedge i_clk); #1;
    n_total++;
    if (o_done !== 1'b0 || o_busy !== 1'b0)
      $display("FAIL %s after_done: done=%b busy=%b want 0 0", name, o_done, o_busy);
    else n_pass++;
  endtask

  task automatic watch_no_done(input string name, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge i_clk); #1;
      if (o_done === 1'b1) seen++;
    end
    n_total++;
    if (seen !== 0) $display("FAIL %s no_done: got %0d pulses want 0", name, seen);
    else n_pass++;
  endtask

  task automatic check_idle(input string name, input bit fall, input int idx);
    n_total++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_fall_in !== fall || o_hole_idx !== IW'(idx))
      $display("FAIL %s state: busy=%b done=%b fall=%b idx=%0d want 0 0 %b %0d",
               name, o_busy, o_done, o_fall_in, o_hole_idx, fall, idx);
    else n_pass++;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_start = 1'b1;
    repeat (3) @(posedge i_clk);
    #1; check_idle("reset", 1'b0, 0);
    @(negedge i_clk); i_rst = 1'b0; i_start = 1'b0;
  endtask

  task automatic test_hit_slot2();
    all_far(); set_hole(2, 110, 110);
    start_scan(100, 100, 3, 1'b1, 2, 200);
    n_total++;
    if (o_busy !== 1'b1) $display("FAIL slot2 busy: got %b want 1", o_busy);
    else n_pass++;
    wait_done("slot2", 0);
    do_clear(); check_idle("slot2_clear", 1'b0, 0);
  endtask

  task automatic test_radius_edge();
    all_far(); set_hole(0, 116, 100);
    start_scan(100, 100, 1, 1'b1, 0, 256);
    wait_done("r256", 0);
    do_clear();
    set_hole(0, 117, 100);
    start_scan(100, 100, 8, 1'b0, 0, 0);
    wait_done("r289", 0);
  endtask

  task automatic test_no_wrap();
    all_far(); set_hole(0, 15, 5);
    start_scan(5, 5, 1, 1'b1, 0, 100);
    wait_done("neg_dx", 0);
    do_clear();
    set_hole(0, 5, 5);
    start_scan(15, 5, 1, 1'b1, 0, 100);
    wait_done("pos_dx", 0);
    do_clear();
    set_hole(0, 4, 5);
    start_scan(1020, 5, 8, 1'b0, 0, 0);
    wait_done("wrap", 0);
  endtask

  task automatic test_priority();
    all_far(); set_hole(1, 105, 100); set_hole(3, 100, 108);
    i_hole_mask = 8'b1111_1101;
    start_scan(100, 100, 4, 1'b1, 3, 64);
    wait_done("masked", 0);
    @(negedge i_clk); i_start = 1'b1;
    @(posedge i_clk); #1; i_start = 1'b0;
    watch_no_done("start_while_fall", 12);
    check_idle("start_while_fall", 1'b1, 3);
    do_clear(); check_idle("masked_clear", 1'b0, 0);
    all_far(); set_hole(1, 105, 100); set_hole(3, 100, 108);
    start_scan(100, 100, 2, 1'b1, 1, 25);
    wait_done("lowest_idx", 0);
    do_clear();
  endtask

  task automatic test_abort();
    exp_t e;
    all_far();
    start_scan(100, 100, 8, 1'b0, 0, 0);
    e = sb.pop_front();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk); i_clear = 1'b1; i_start = 1'b1;
    @(posedge i_clk); #1; i_clear = 1'b0; i_start = 1'b0;
    check_idle("clear_abort", 1'b0, 0);
    watch_no_done("clear_abort", 12);
  endtask

  task automatic test_start_while_busy();
    all_far();
    start_scan(100, 100, 8, 1'b0, 0, 0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk); i_start = 1'b1;
    @(posedge i_clk); #1; i_start = 1'b0;
    wait_done("busy_start", 3);
    watch_no_done("busy_start", 12);
  endtask

  task automatic test_rst_mid_scan();
    all_far(); set_hole(5, 100, 100);
    start_scan(100, 100, 6, 1'b1, 5, 0);
    void'(sb.pop_front());
    repeat (2) @(posedge i_clk);
    @(negedge i_clk); i_rst = 1'b1;
    @(posedge i_clk); #1; i_rst = 1'b0;
    check_idle("rst_mid", 1'b0, 0);
    watch_no_done("rst_mid", 12);
    check_idle("rst_mid_after", 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_hit_slot2();
    test_radius_edge();
    test_no_wrap();
    test_priority();
    test_abort();
    test_start_while_busy();
    test_rst_mid_scan();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
